// File: rtl/week_5_nor_selftest_ctrl_pkg.sv
// Shared types and constants for the NOR gate self-test controller.
package week_5_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;

  // Bit i is the NOR output for vector i, where a = i[1] and b = i[0].
  localparam logic [NUM_VECTORS-1:0] NOR_EXPECTED = 4'b0001;

  function automatic logic expected_y(input logic [1:0] idx);
    return NOR_EXPECTED[idx];
  endfunction

endpackage

// File: rtl/week_5_nor_selftest_ctrl_if.sv
// Handshake, result and gate-under-test signals of the self-test controller.
interface week_5_nor_selftest_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic             abort;
  logic             dut_y;
  logic             dut_a;
  logic             dut_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [3:0]       fail_mask;

  // Lab top level / bench side: requests runs, closes the loop through the gate.
  modport master (
    output start, abort, dut_y,
    input  dut_a, dut_b, busy, done, pass, pass_count, fail_count, fail_mask
  );

  // Controller side.
  modport slave (
    input  start, abort, dut_y,
    output dut_a, dut_b, busy, done, pass, pass_count, fail_count, fail_mask
  );
endinterface

// File: rtl/week_5_settle_timer.sv
// Loadable 4-bit down-counter with a zero flag; paces each vector's settle window.
module week_5_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] count;

  // Load takes priority over counting down.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values, independent of statement or process order.
    if (!rst_n)    count <= 4'd0;
    else if (load) count <= load_val;
    else if (en)   count <= count - 4'd1;
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/week_5_nor_selftest_ctrl.sv
// Walks a 2-input NOR gate through all four input vectors, samples its
// output after a settle window and reports per-vector and overall results.
module week_5_nor_selftest_ctrl
  import week_5_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  week_5_nor_selftest_ctrl_if.slave   bus
);

  state_t           state, next_state;
  logic [1:0]       idx;
  logic             dut_a, dut_b, pass;
  logic [CNT_W-1:0] pass_count, fail_count;
  logic [3:0]       fail_mask;

  logic start_run, abort_run, sample_now, tmr_load, tmr_en, tmr_zero, match;
  logic [1:0] idx_next;

  localparam logic [3:0] TIMER_RELOAD = 4'(SETTLE_CYCLES - 1);

  week_5_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TIMER_RELOAD),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign match    = (bus.dut_y == expected_y(idx));
  assign idx_next = idx + 2'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and per-cycle control strobes; abort wins over a sample update.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    next_state = state;
    start_run  = 1'b0;
    abort_run  = 1'b0;
    sample_now = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = SETTLE;
          start_run  = 1'b1;
          tmr_load   = 1'b1;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          next_state = IDLE;
          abort_run  = 1'b1;
        end else if (tmr_zero) begin
          next_state = SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          next_state = IDLE;
          abort_run  = 1'b1;
        end else begin
          sample_now = 1'b1;
          if (idx == 2'd3) begin
            next_state = DONE;
          end else begin
            next_state = SETTLE;
            tmr_load   = 1'b1;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Vector register and result registers; results hold until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 2'd0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      pass       <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      fail_mask  <= 4'b0000;
    end else if (start_run || abort_run) begin
      // Vector 0 is 00, so starting and aborting both drive the gate low.
      idx        <= 2'd0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      pass       <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      fail_mask  <= 4'b0000;
    end else if (sample_now) begin
      if (match) begin
        pass_count <= pass_count + CNT_W'(1);
      end else begin
        fail_count     <= fail_count + CNT_W'(1);
        fail_mask[idx] <= 1'b1;
      end
      if (idx == 2'd3) begin
        dut_a <= 1'b0;
        dut_b <= 1'b0;
        // Final verdict includes the vector being sampled on this edge.
        pass  <= (fail_count == '0) && match;
      end else begin
        idx   <= idx_next;
        dut_a <= idx_next[1];
        dut_b <= idx_next[0];
      end
    end
  end

  assign bus.dut_a      = dut_a;
  assign bus.dut_b      = dut_b;
  assign bus.busy       = (state == SETTLE) || (state == SAMPLE);
  assign bus.done       = (state == DONE);
  assign bus.pass       = pass;
  assign bus.pass_count = pass_count;
  assign bus.fail_count = fail_count;
  assign bus.fail_mask  = fail_mask;

endmodule

// File: tb/tb_week_5_nor_selftest_ctrl.sv
// Directed bench for the NOR self-test controller; the gate under test is
// modelled here so faulty gates can be substituted.
module tb_week_5_nor_selftest_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   gate_mode = 0;  // 0: NOR, 1: OR, 2: output stuck at 0

  week_5_nor_selftest_ctrl_if #(.CNT_W(3)) bus ();

  week_5_nor_selftest_ctrl #(.SETTLE_CYCLES(2), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.dut_y = (gate_mode == 0) ? ~(bus.dut_a | bus.dut_b) :
                     (gate_mode == 1) ?  (bus.dut_a | bus.dut_b) : 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " busy"},  bus.busy, 0);
    check({tag, " done"},  bus.done, 0);
    check({tag, " dut_a"}, bus.dut_a, 0);
    check({tag, " dut_b"}, bus.dut_b, 0);
    check({tag, " pass"},  bus.pass, 0);
    check({tag, " pcnt"},  bus.pass_count, 0);
    check({tag, " fcnt"},  bus.fail_count, 0);
    check({tag, " mask"},  bus.fail_mask, 0);
  endtask

  // One complete run: start accepted at E0, done expected in cycle 12.
  task automatic run(input string tag, input int mode, input bit hold_start,
                     input logic [2:0] pc, input logic [2:0] fc,
                     input logic [3:0] mask, input logic p);
    logic [1:0] v;
    gate_mode = mode;
    bus.start = 1'b1;
    step();
    if (!hold_start) bus.start = 1'b0;
    check({tag, " cleared pass"}, bus.pass, 0);
    check({tag, " cleared pcnt"}, bus.pass_count, 0);
    check({tag, " cleared fcnt"}, bus.fail_count, 0);
    check({tag, " cleared mask"}, bus.fail_mask, 0);
    for (int c = 0; c < 12; c++) begin
      v = 2'(c / 3);
      check($sformatf("%s c%0d dut_a", tag, c), bus.dut_a, v[1]);
      check($sformatf("%s c%0d dut_b", tag, c), bus.dut_b, v[0]);
      check($sformatf("%s c%0d busy", tag, c), bus.busy, 1);
      check($sformatf("%s c%0d done", tag, c), bus.done, 0);
      step();
    end
    check({tag, " c12 done"}, bus.done, 1);
    check({tag, " c12 busy"}, bus.busy, 0);
    check({tag, " c12 pass"}, bus.pass, p);
    check({tag, " c12 pcnt"}, bus.pass_count, pc);
    check({tag, " c12 fcnt"}, bus.fail_count, fc);
    check({tag, " c12 mask"}, bus.fail_mask, mask);
    check({tag, " c12 dut_a"}, bus.dut_a, 0);
    bus.start = 1'b0;
    step();
    step();
    check({tag, " idle done"}, bus.done, 0);
    check({tag, " idle busy"}, bus.busy, 0);
    check({tag, " hold pass"}, bus.pass, p);
    check({tag, " hold pcnt"}, bus.pass_count, pc);
    check({tag, " hold fcnt"}, bus.fail_count, fc);
    check({tag, " hold mask"}, bus.fail_mask, mask);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    repeat (3) step();
    check_cleared("reset");

    rst_n     = 1'b1;
    bus.start = 1'b0;
    repeat (3) step();
    check("post-reset busy", bus.busy, 0);
    check("post-reset done", bus.done, 0);

    run("nor",   0, 1'b0, 3'd4, 3'd0, 4'b0000, 1'b1);
    run("or",    1, 1'b0, 3'd0, 3'd4, 4'b1111, 1'b0);
    run("stuck", 2, 1'b0, 3'd3, 3'd1, 4'b0001, 1'b0);
    run("rerun", 0, 1'b0, 3'd4, 3'd0, 4'b0000, 1'b1);
    run("held",  0, 1'b1, 3'd4, 3'd0, 4'b0000, 1'b1);
    repeat (3) step();
    check("held no restart busy", bus.busy, 0);

    // Abort in cycle 5, which is the sample cycle of vector 1.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    check("abort pre pcnt", bus.pass_count, 1);
    check("abort pre busy", bus.busy, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_cleared("abort c6");
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("abort no done %0d", i), bus.done, 0);
    end
    check("abort still idle", bus.busy, 0);

    // Asynchronous reset in the middle of cycle 7.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    check("midrun dut_a", bus.dut_a, 1);
    check("midrun pcnt", bus.pass_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async reset");
    step();
    rst_n = 1'b1;
    step();
    check("after reset idle", bus.busy, 0);
    run("post-reset", 0, 1'b0, 3'd4, 3'd0, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
